// File: rtl/axa_pkg.sv
// Shared types and helpers for the approximate-adder sweep sequencer.
// Sums and errors are worked in int so any legal operand width fits without overflow.
package axa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SETTLE_MAX = 15;

    function automatic int exact_sum(input int a, input int b);
        return a + b;
    endfunction

    function automatic int abs_err(input int approx, input int exact);
        return (approx >= exact) ? approx - exact : exact - approx;
    endfunction

    function automatic bit out_w_ok(input int operand_w, input int out_w);
        return out_w == operand_w + 1;
    endfunction

endpackage

// File: rtl/axa_err_acc.sv
// Error computation for one vector plus the running statistics registers
// (max error, nonzero-error count, first-failure capture, final pass flag).
module axa_err_acc
    import axa_pkg::*;
#(
    parameter int OPERAND_W = 2,
    parameter int OUT_W     = 3,
    parameter int ET        = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   last,
    input  logic [OPERAND_W-1:0]   op_a,
    input  logic [OPERAND_W-1:0]   op_b,
    input  logic [OUT_W-1:0]       approx_sum,
    output logic                   err_over,
    output logic [OUT_W-1:0]       max_err,
    output logic [2*OPERAND_W:0]   err_cnt,
    output logic [2*OPERAND_W-1:0] fail_vec,
    output logic                   fail_valid,
    output logic                   pass
);

    localparam int CNT_W = 2 * OPERAND_W + 1;

    logic [OUT_W-1:0] err;
    logic [OUT_W-1:0] max_next;

    assign err      = OUT_W'(abs_err(int'(approx_sum), exact_sum(int'(op_a), int'(op_b))));
    assign max_next = (err > max_err) ? err : max_err;
    assign err_over = int'(err) > ET;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err    <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
        end else if (clear) begin
            max_err    <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
        end else if (en) begin
            max_err <= max_next;
            if (err != '0)
                err_cnt <= err_cnt + CNT_W'(1);
            if (err_over && !fail_valid) begin
                fail_vec   <= {op_b, op_a};
                fail_valid <= 1'b1;
            end
            // pass must include the vector being checked on the closing edge
            if (last)
                pass <= int'(max_next) <= ET;
        end
    end

endmodule

// File: rtl/axa_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every {op_b,op_a} into a combinational
// approximate adder and accumulates error statistics against the exact sum.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; statistics held
//   ST_SETTLE | operands held, settle down-counter running
//   ST_CHECK  | sample approx_sum, update statistics, advance or finish
//   ST_DONE   | one-cycle done pulse, then back to idle
module axa_sweep_ctrl
    import axa_pkg::*;
#(
    parameter int OPERAND_W    = 2,
    parameter int OUT_W        = 3,
    parameter int ET           = 0,
    parameter int SETTLE       = 0,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [OPERAND_W-1:0]   op_a,
    output logic [OPERAND_W-1:0]   op_b,
    input  logic [OUT_W-1:0]       approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   pass,
    output logic [OUT_W-1:0]       max_err,
    output logic [2*OPERAND_W:0]   err_cnt,
    output logic [2*OPERAND_W-1:0] fail_vec,
    output logic                   fail_valid
);

    localparam int         VEC_W     = 2 * OPERAND_W;
    localparam logic [3:0] SETTLE_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    if (!out_w_ok(OPERAND_W, OUT_W)) begin : g_bad_out_w
        $error("axa_sweep_ctrl: OUT_W must equal OPERAND_W+1");
    end
    if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("axa_sweep_ctrl: SETTLE out of range 0..15");
    end

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [3:0]       settle_cnt;
    logic             err_over;
    logic             acc_clear;
    logic             acc_en;
    logic             stop;

    assign {op_b, op_a} = vec;
    assign acc_clear    = (state == ST_IDLE) && start;
    assign acc_en       = (state == ST_CHECK) && !abort;
    assign stop         = (&vec) || ((STOP_ON_FAIL != 0) && err_over);

    axa_err_acc #(
        .OPERAND_W (OPERAND_W),
        .OUT_W     (OUT_W),
        .ET        (ET)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (acc_clear),
        .en         (acc_en),
        .last       (stop),
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_sum (approx_sum),
        .err_over   (err_over),
        .max_err    (max_err),
        .err_cnt    (err_cnt),
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid),
        .pass       (pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec  <= '0;
                        busy <= 1'b1;
                        if (SETTLE > 0) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (stop) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec <= vec + VEC_W'(1);
                        if (SETTLE > 0) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axa_sweep_ctrl.sv
// Directed bench: four sweep controllers with different parameter sets, each
// fed by a behavioural adder model selected per instance.
module tb_axa_sweep_ctrl;

    logic clk;
    logic rst_n;

    logic       start      [4];
    logic       abort      [4];
    logic [1:0] op_a       [4];
    logic [1:0] op_b       [4];
    logic [2:0] approx     [4];
    logic       busy       [4];
    logic       done       [4];
    logic       aborted    [4];
    logic       pass       [4];
    logic [2:0] max_err    [4];
    logic [4:0] err_cnt    [4];
    logic [3:0] fail_vec   [4];
    logic       fail_valid [4];
    int         mode       [4];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: exact adder, 1: output stuck at 0, 2: +1 error only at vector 9
    function automatic logic [2:0] adder_model(input int m, input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (m == 1) s = 3'd0;
        if (m == 2 && {b, a} == 4'd9) s = s + 3'd1;
        return s;
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) approx[k] = adder_model(mode[k], op_a[k], op_b[k]);
    end

    axa_sweep_ctrl u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .approx_sum(approx[0]),
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .pass(pass[0]),
        .max_err(max_err[0]), .err_cnt(err_cnt[0]), .fail_vec(fail_vec[0]),
        .fail_valid(fail_valid[0]));

    axa_sweep_ctrl #(.SETTLE(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .approx_sum(approx[1]),
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .pass(pass[1]),
        .max_err(max_err[1]), .err_cnt(err_cnt[1]), .fail_vec(fail_vec[1]),
        .fail_valid(fail_valid[1]));

    axa_sweep_ctrl #(.STOP_ON_FAIL(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .op_a(op_a[2]), .op_b(op_b[2]), .approx_sum(approx[2]),
        .busy(busy[2]), .done(done[2]), .aborted(aborted[2]), .pass(pass[2]),
        .max_err(max_err[2]), .err_cnt(err_cnt[2]), .fail_vec(fail_vec[2]),
        .fail_valid(fail_valid[2]));

    axa_sweep_ctrl #(.ET(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]),
        .op_a(op_a[3]), .op_b(op_b[3]), .approx_sum(approx[3]),
        .busy(busy[3]), .done(done[3]), .aborted(aborted[3]), .pass(pass[3]),
        .max_err(max_err[3]), .err_cnt(err_cnt[3]), .fail_vec(fail_vec[3]),
        .fail_valid(fail_valid[3]));

    // Cycle c is the period after the (c-1)th rising edge counted from the start edge (edge 0).
    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1 start[i] = 1'b0;
    endtask

    task automatic run_sweep(input int i, input int budget, output int done_cyc);
        done_cyc = -1;
        pulse_start(i);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done[i] === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({op_b[0], op_a[0], busy[0], done[0], aborted[0], pass[0], max_err[0],
             err_cnt[0], fail_vec[0], fail_valid[0]} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got op=%h busy=%b done=%b pass=%b max_err=%0d err_cnt=%0d required all zero",
                     {op_b[0], op_a[0]}, busy[0], done[0], pass[0], max_err[0], err_cnt[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exact();
        int dc;
        mode[0] = 0;
        run_sweep(0, 40, dc);
        checks++;
        if (dc !== 17) begin errors++; $display("FAIL exact_done_cycle: got %0d required 17", dc); end
        checks++;
        if ({pass[0], max_err[0], err_cnt[0], fail_valid[0]} !== {1'b1, 3'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL exact_stats: got pass=%b max_err=%0d err_cnt=%0d fail_valid=%b required 1 0 0 0",
                     pass[0], max_err[0], err_cnt[0], fail_valid[0]);
        end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || pass[0] !== 1'b1) begin
            errors++;
            $display("FAIL exact_done_pulse: got done=%b pass=%b required done=0 pass=1", done[0], pass[0]);
        end
    endtask

    task automatic test_zero_out();
        int dc;
        mode[0] = 1;
        run_sweep(0, 40, dc);
        checks++;
        if (dc !== 17) begin errors++; $display("FAIL zero_done_cycle: got %0d required 17", dc); end
        checks++;
        if (max_err[0] !== 3'd6 || err_cnt[0] !== 5'd15) begin
            errors++;
            $display("FAIL zero_err: got max_err=%0d err_cnt=%0d required 6 15", max_err[0], err_cnt[0]);
        end
        checks++;
        if (fail_vec[0] !== 4'd1 || fail_valid[0] !== 1'b1 || pass[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_fail: got fail_vec=%0d fail_valid=%b pass=%b required 1 1 0",
                     fail_vec[0], fail_valid[0], pass[0]);
        end
    endtask

    task automatic test_settle();
        int dc;
        logic [3:0] ops [50];
        logic       bz  [50];
        mode[1] = 0;
        dc = -1;
        pulse_start(1);
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            ops[c] = {op_b[1], op_a[1]};
            bz[c]  = busy[1];
            if (done[1] === 1'b1 && dc < 0) dc = c;
        end
        checks++;
        if (dc !== 49) begin errors++; $display("FAIL settle_done_cycle: got %0d required 49", dc); end
        checks++;
        if (ops[1] !== 4'd0 || ops[3] !== 4'd0 || ops[4] !== 4'd1 || ops[6] !== 4'd1 || ops[7] !== 4'd2) begin
            errors++;
            $display("FAIL settle_op_hold: got c1=%0d c3=%0d c4=%0d c6=%0d c7=%0d required 0 0 1 1 2",
                     ops[1], ops[3], ops[4], ops[6], ops[7]);
        end
        checks++;
        if (bz[1] !== 1'b1 || bz[48] !== 1'b1 || bz[49] !== 1'b0) begin
            errors++;
            $display("FAIL settle_busy: got c1=%b c48=%b c49=%b required 1 1 0", bz[1], bz[48], bz[49]);
        end
        checks++;
        if (pass[1] !== 1'b1 || err_cnt[1] !== 5'd0) begin
            errors++;
            $display("FAIL settle_stats: got pass=%b err_cnt=%0d required 1 0", pass[1], err_cnt[1]);
        end
    endtask

    task automatic test_stop_on_fail();
        int dc;
        mode[2] = 2;
        run_sweep(2, 40, dc);
        // vectors 0..9 are checked, so done follows 10 CHECK cycles
        checks++;
        if (dc !== 11) begin errors++; $display("FAIL stop_done_cycle: got %0d required 11", dc); end
        checks++;
        if (fail_vec[2] !== 4'd9 || fail_valid[2] !== 1'b1 || err_cnt[2] !== 5'd1) begin
            errors++;
            $display("FAIL stop_fail: got fail_vec=%0d fail_valid=%b err_cnt=%0d required 9 1 1",
                     fail_vec[2], fail_valid[2], err_cnt[2]);
        end
        checks++;
        if (max_err[2] !== 3'd1 || pass[2] !== 1'b0) begin
            errors++;
            $display("FAIL stop_result: got max_err=%0d pass=%b required 1 0", max_err[2], pass[2]);
        end
    endtask

    task automatic test_et_tolerance();
        int dc;
        mode[3] = 2;
        run_sweep(3, 40, dc);
        checks++;
        if (dc !== 17) begin errors++; $display("FAIL et1_done_cycle: got %0d required 17", dc); end
        checks++;
        if ({pass[3], max_err[3], err_cnt[3], fail_valid[3]} !== {1'b1, 3'd1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL et1_stats: got pass=%b max_err=%0d err_cnt=%0d fail_valid=%b required 1 1 1 0",
                     pass[3], max_err[3], err_cnt[3], fail_valid[3]);
        end
    endtask

    task automatic test_abort();
        int  dc;
        bit  seen_done;
        logic [3:0] op_c4;
        mode[0] = 1;
        pulse_start(0);
        @(negedge clk);                 // cycle 1
        @(negedge clk);                 // cycle 2
        start[0] = 1'b1;                // ignored while busy
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(negedge clk);                 // cycle 3
        @(negedge clk);                 // cycle 4
        op_c4 = {op_b[0], op_a[0]};
        checks++;
        if (op_c4 !== 4'd3) begin errors++; $display("FAIL abort_start_ignored: got vec=%0d required 3", op_c4); end
        @(negedge clk);                 // cycle 5
        @(negedge clk);                 // cycle 6, vec 5 in CHECK
        checks++;
        if ({op_b[0], op_a[0]} !== 4'd5) begin
            errors++;
            $display("FAIL abort_vec: got vec=%0d required 5", {op_b[0], op_a[0]});
        end
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (aborted[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: got aborted=%b busy=%b done=%b required 1 0 0", aborted[0], busy[0], done[0]);
        end
        checks++;
        if (err_cnt[0] !== 5'd4 || max_err[0] !== 3'd3 || fail_vec[0] !== 4'd1 ||
            fail_valid[0] !== 1'b1 || pass[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_stats: got err_cnt=%0d max_err=%0d fail_vec=%0d fail_valid=%b pass=%b required 4 3 1 1 0",
                     err_cnt[0], max_err[0], fail_vec[0], fail_valid[0], pass[0]);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || aborted[0] === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL abort_quiet: got done/aborted after abort required none"); end
        abort[0] = 1'b1;                // idle abort ignored
        @(posedge clk);
        #1 abort[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (aborted[0] !== 1'b0) begin errors++; $display("FAIL abort_idle: got aborted=%b required 0", aborted[0]); end
        mode[0] = 0;
        run_sweep(0, 40, dc);
        checks++;
        if (dc !== 17 || err_cnt[0] !== 5'd0 || max_err[0] !== 3'd0 || fail_valid[0] !== 1'b0 || pass[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got cyc=%0d err_cnt=%0d max_err=%0d fail_valid=%b pass=%b required 17 0 0 0 1",
                     dc, err_cnt[0], max_err[0], fail_valid[0], pass[0]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit seen;
        mode[0] = 1;
        pulse_start(0);
        for (int c = 0; c < 8; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({op_b[0], op_a[0], busy[0], done[0], aborted[0], pass[0], max_err[0],
             err_cnt[0], fail_vec[0], fail_valid[0]} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset: got op=%0d busy=%b max_err=%0d err_cnt=%0d fail_valid=%b required all zero",
                     {op_b[0], op_a[0]}, busy[0], max_err[0], err_cnt[0], fail_valid[0]);
        end
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || aborted[0] === 1'b1 || busy[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_reset_quiet: got activity after reset required idle"); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 4; k++) begin
            start[k] = 1'b0;
            abort[k] = 1'b0;
            mode[k]  = 0;
        end
        test_reset();
        test_exact();
        test_zero_out();
        test_settle();
        test_stop_on_fail();
        test_et_tolerance();
        test_abort();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
